// File: rtl/mem_responder.sv
// Memory responder: serves one read or write per request from a word array after programmable wait states.
// Latency: ready pulses in the (WAIT_CYCLES+1)th cycle after the edge that samples the request.
// Backpressure: none; the initiator holds mem_read/mem_write until ready and must drop them on seeing it.
//
// Ports:
//   clk_i        rising-edge clock
//   init_i       synchronous reset, active-low (array contents are kept, in-flight request aborted)
//   mem_read_i   read request strobe, held until ready
//   mem_write_i  write request strobe, held until ready (wins over mem_read_i)
//   addr_i       word address, held with the request
//   wdata_i      write data, held with mem_write_i
//   rdata_o      registered read data, updated only when a read completes
//   ready_o      one-cycle completion pulse
//   busy_o       high while a request is in WAIT or RESP
//   rd_count_o   completed-read counter  (only with MEM_ACCESS_CNT_EN, else 0)
//   wr_count_o   completed-write counter (only with MEM_ACCESS_CNT_EN, else 0)
// Optional feature macro: MEM_ACCESS_CNT_EN enables the two 16-bit access counters.
module mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              init_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              enter_resp;
  logic              req_vld;
  req_t              live_req;
  req_t              cur_req;
  logic              mem_we;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign req_vld        = mem_read_i | mem_write_i;
  // Simultaneous read and write strobes are treated as a write.
  assign live_req.is_wr = mem_write_i;
  assign live_req.addr  = addr_i;
  assign live_req.wdata = wdata_i;

  // With zero wait states RESP is entered on the sampling edge itself, before
  // the request registers hold anything, so the live inputs are used there.
  assign cur_req = (state_q == S_IDLE) ? live_req : req_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_vld) begin
          req_d = live_req;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data is captured only when a read completes; otherwise it holds.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !cur_req.is_wr) begin
      rdata_d = mem[cur_req.addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!init_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by init_i so a write aborted by reset on its commit edge never lands.
  assign mem_we = init_i & enter_resp & cur_req.is_wr;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[cur_req.addr] <= cur_req.wdata;
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = (state_q == S_RESP);
  assign busy_o  = (state_q != S_IDLE);

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (enter_resp) begin
      if (cur_req.is_wr) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!init_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`else
  assign rd_count_o = 16'h0000;
  assign wr_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (2 and 0 wait states) driven by request tasks.
// Latency: each expected response is queued at issue and checked when ready pulses.
// Backpressure: the driver holds its strobe until ready, then drops it.
module tb_mem_responder;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int WC0 = 2;
  localparam int WC1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          init_n;
  logic          rd    [2];
  logic          wr    [2];
  logic [AW-1:0] ad    [2];
  logic [DW-1:0] wd    [2];
  logic [DW-1:0] rdata [2];
  logic          ready [2];
  logic          busy  [2];
  logic [15:0]   rdc   [2];
  logic [15:0]   wrc   [2];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC0)) u_dut_w2 (
    .clk_i(clk), .init_i(init_n), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
    .addr_i(ad[0]), .wdata_i(wd[0]), .rdata_o(rdata[0]), .ready_o(ready[0]),
    .busy_o(busy[0]), .rd_count_o(rdc[0]), .wr_count_o(wrc[0])
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC1)) u_dut_w0 (
    .clk_i(clk), .init_i(init_n), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
    .addr_i(ad[1]), .wdata_i(wd[1]), .rdata_o(rdata[1]), .ready_o(ready[1]),
    .busy_o(busy[1]), .rd_count_o(rdc[1]), .wr_count_o(wrc[1])
  );

  typedef struct {
    bit          is_rd;
    logic [15:0] exp_rdata;
    int          sample;
    logic [15:0] exp_rdc;
    logic [15:0] exp_wrc;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: word array, last completed read value, access counts.
  logic [15:0] mdl    [2][4096];
  logic [15:0] m_last [2];
  logic [15:0] m_rdc  [2];
  logic [15:0] m_wrc  [2];
  logic [AW-1:0] wlist0[$];
  logic [AW-1:0] wlist1[$];

  int run [2];
  bit prev_ready [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wc_of(int k);
    return (k == 0) ? WC0 : WC1;
  endfunction

  // Monitor: pops one expectation per ready pulse and checks it.
  always @(negedge clk) begin
    sb_t e;
    bit  have;
    for (int k = 0; k < 2; k++) begin
      if (busy[k] === 1'b1) run[k] = run[k] + 1;
      else run[k] = 0;
      if (ready[k] === 1'b1) begin
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          chk("unexpected_ready", 32'(ready[k]), 32'd0);
        end else begin
          chk("ready_latency", 32'(cyc - e.sample), 32'(wc_of(k)));
          chk("busy_length", 32'(run[k]), 32'(wc_of(k) + 1));
          chk("ready_back_to_back", 32'(prev_ready[k]), 32'd0);
          chk(e.is_rd ? "rdata_read" : "rdata_hold", 32'(rdata[k]), 32'(e.exp_rdata));
`ifdef MEM_ACCESS_CNT_EN
          chk("rd_count", 32'(rdc[k]), 32'(e.exp_rdc));
          chk("wr_count", 32'(wrc[k]), 32'(e.exp_wrc));
`else
          chk("rd_count_tied", 32'(rdc[k]), 32'd0);
          chk("wr_count_tied", 32'(wrc[k]), 32'd0);
`endif
        end
      end
      prev_ready[k] = (ready[k] === 1'b1);
    end
  end

  // Issue one request on instance k; optionally change addr during the wait.
  task automatic req(int k, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d, bit toggle);
    sb_t e;
    int  n;
    @(negedge clk);
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    e.sample = cyc + 1;
    if (w) begin
      mdl[k][a] = d;
      m_wrc[k]  = m_wrc[k] + 16'd1;
      e.is_rd   = 1'b0;
      if (k == 0) wlist0.push_back(a); else wlist1.push_back(a);
    end else begin
      m_last[k] = mdl[k][a];
      m_rdc[k]  = m_rdc[k] + 16'd1;
      e.is_rd   = 1'b1;
    end
    e.exp_rdata = m_last[k];
    e.exp_rdc   = m_rdc[k];
    e.exp_wrc   = m_wrc[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (toggle && n == 1) ad[k] = a + 12'd1;
    end while (ready[k] !== 1'b1 && n < 40);
    if (ready[k] !== 1'b1) chk("ready_timeout", 32'(ready[k]), 32'd1);
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 16'h0000;
      m_rdc[k]  = 16'h0000;
      m_wrc[k]  = 16'h0000;
    end
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(ready[k]), 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'd0);
      chk("reset_rdata", 32'(rdata[k]), 32'd0);
      chk("reset_rd_count", 32'(rdc[k]), 32'd0);
      chk("reset_wr_count", 32'(wrc[k]), 32'd0);
    end
  endtask

  // Write on instance 0 aborted by reset on the edge that would commit it.
  task automatic abort_write(logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = a; wd[0] = d;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_in_wait", 32'(busy[0]), 32'd1);
    init_n = 1'b0;
    wr[0]  = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    model_reset();
    check_reset_state();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
      run[k] = 0; prev_ready[k] = 1'b0;
    end
    model_reset();
    init_n = 1'b0;
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    // Write then read back, wait-state instance.
    req(0, 0, 1, 12'h005, 16'hBEEF, 0);
    req(0, 1, 0, 12'h005, 16'h0000, 0);
    // Address changed during the wait must be ignored.
    req(0, 0, 1, 12'h006, 16'h1111, 0);
    req(0, 1, 0, 12'h005, 16'h0000, 1);
    // Both strobes behave as a write; rdata holds, then read returns the data.
    req(0, 1, 1, 12'h0FF, 16'h1234, 0);
    req(0, 1, 0, 12'h0FF, 16'h0000, 0);
    // Top-of-range address.
    req(0, 0, 1, 12'hFFF, 16'hC0DE, 0);
    req(0, 1, 0, 12'hFFF, 16'h0000, 0);
    // Aborted write leaves previous contents.
    req(0, 0, 1, 12'h010, 16'h5A5A, 0);
    abort_write(12'h010, 16'hAAAA);
    req(0, 1, 0, 12'h010, 16'h0000, 0);

    // Zero wait states: 2 writes + 3 reads.
    req(1, 0, 1, 12'h020, 16'h0102, 0);
    req(1, 0, 1, 12'h021, 16'h0304, 0);
    req(1, 1, 0, 12'h020, 16'h0000, 0);
    req(1, 1, 0, 12'h021, 16'h0000, 0);
    req(1, 1, 0, 12'h020, 16'h0000, 0);

    // Randomized mix on both instances; reads only touch written words.
    for (int i = 0; i < 120; i++) begin
      int k;
      k  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (op <= 1) begin
        if (k == 0) a = wlist0[$urandom_range(0, wlist0.size() - 1)];
        else        a = wlist1[$urandom_range(0, wlist1.size() - 1)];
        req(k, 1, 0, a, DW'($urandom), bit'($urandom_range(0, 1)));
      end else begin
        a = AW'($urandom);
        req(k, bit'(op == 3), 1, a, DW'($urandom), 0);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
